// File: rtl/alu_issue_ctrl.sv
// Operand/issue stage in front of the 16-bit ALU: register file, carry flag, handshake and write-back.
// Optional macro ALU_ISSUE_BYPASS_EN: accept during EXEC with result/carry forwarding (1 op per cycle).
//
// state | meaning
// IDLE  | no op in flight, alu_* outputs holding last operands
// EXEC  | ALU op in flight, result written back at the end of this cycle
module alu_issue_ctrl #(
    parameter int WIDTH = 16,
    parameter int NREG  = 4,
    parameter int AW    = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             instr_valid_i,
    output logic             instr_ready_o,
    input  logic             instr_ld_i,
    input  logic [3:0]       instr_op_i,
    input  logic [AW-1:0]    instr_rd_i,
    input  logic [AW-1:0]    instr_rs_i,
    input  logic [AW-1:0]    instr_rt_i,
    input  logic             instr_cuse_i,
    input  logic [WIDTH-1:0] instr_imm_i,
    output logic [WIDTH-1:0] alu_a_o,
    output logic [WIDTH-1:0] alu_b_o,
    output logic [3:0]       alu_op_o,
    output logic             alu_c_o,
    input  logic [WIDTH-1:0] alu_f_i,
    input  logic             alu_c_i,
    output logic             done_o,
    input  logic [AW-1:0]    dbg_addr_i,
    output logic [WIDTH-1:0] dbg_data_o,
    output logic             dbg_carry_o
);

    typedef enum logic {IDLE, EXEC} state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] regs [NREG];
    logic             flag;
    logic [AW-1:0]    rd_q;
    logic             accept;
    logic             accept_alu;
    logic             accept_ld;
    logic             wr_alu;
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic             src_c;

    assign accept     = instr_valid_i & instr_ready_o;
    assign accept_alu = accept & ~instr_ld_i;
    assign accept_ld  = accept & instr_ld_i;
    assign wr_alu     = (state == EXEC);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept_alu) state_nxt = EXEC;
            end
            EXEC: begin
`ifdef ALU_ISSUE_BYPASS_EN
                state_nxt = accept_alu ? EXEC : IDLE;
`else
                state_nxt = IDLE;
`endif
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
`ifdef ALU_ISSUE_BYPASS_EN
        instr_ready_o = 1'b1;
`else
        instr_ready_o = (state == IDLE);
`endif
    end

    // Operands are read at accept, so rd == rs sees the pre-write value.
    always_comb begin
        src_a = regs[instr_rs_i];
        src_b = regs[instr_rt_i];
        src_c = instr_cuse_i & flag;
`ifdef ALU_ISSUE_BYPASS_EN
        if (state == EXEC) begin
            if (instr_rs_i == rd_q) src_a = alu_f_i;
            if (instr_rt_i == rd_q) src_b = alu_f_i;
            if (instr_cuse_i)       src_c = alu_c_i;
        end
`endif
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
            flag     <= 1'b0;
            rd_q     <= '0;
            alu_a_o  <= '0;
            alu_b_o  <= '0;
            alu_op_o <= '0;
            alu_c_o  <= 1'b0;
            done_o   <= 1'b0;
        end else begin
            if (accept_alu) begin
                alu_a_o  <= src_a;
                alu_b_o  <= src_b;
                alu_op_o <= instr_op_i;
                alu_c_o  <= src_c;
                rd_q     <= instr_rd_i;
            end
            if (wr_alu) begin
                regs[rd_q] <= alu_f_i;
                flag       <= alu_c_i;
            end
            // Placed after the ALU write-back so a same-edge load to the same rd wins.
            if (accept_ld) regs[instr_rd_i] <= instr_imm_i;
            done_o <= wr_alu | accept_ld;
        end
    end

    assign dbg_data_o  = regs[dbg_addr_i];
    assign dbg_carry_o = flag;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: vector table with a write-back scoreboard, plus hold-valid and mid-EXEC reset sequences.
// A small behavioural ALU closes the loop from alu_* outputs back to alu_f_i/alu_c_i.
module tb_alu_issue_ctrl;

`ifdef ALU_ISSUE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_AND = 4'b1000;
    localparam logic [3:0] OP_NOT = 4'b1100;

    logic        clk = 1'b0;
    logic        rst;
    logic        instr_valid;
    logic        instr_ready;
    logic        instr_ld;
    logic [3:0]  instr_op;
    logic [1:0]  instr_rd;
    logic [1:0]  instr_rs;
    logic [1:0]  instr_rt;
    logic        instr_cuse;
    logic [15:0] instr_imm;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic [3:0]  alu_op;
    logic        alu_cin;
    logic [15:0] alu_f;
    logic        alu_c;
    logic        done;
    logic [1:0]  dbg_addr;
    logic [15:0] dbg_data;
    logic        dbg_carry;

    always #5 clk = ~clk;

    alu_issue_ctrl #(.WIDTH(16), .NREG(4), .AW(2)) dut (
        .clk_i(clk), .rst_i(rst),
        .instr_valid_i(instr_valid), .instr_ready_o(instr_ready),
        .instr_ld_i(instr_ld), .instr_op_i(instr_op),
        .instr_rd_i(instr_rd), .instr_rs_i(instr_rs), .instr_rt_i(instr_rt),
        .instr_cuse_i(instr_cuse), .instr_imm_i(instr_imm),
        .alu_a_o(alu_a), .alu_b_o(alu_b), .alu_op_o(alu_op), .alu_c_o(alu_cin),
        .alu_f_i(alu_f), .alu_c_i(alu_c),
        .done_o(done),
        .dbg_addr_i(dbg_addr), .dbg_data_o(dbg_data), .dbg_carry_o(dbg_carry)
    );

    function automatic logic [16:0] alu_model(input logic [3:0] op, input logic [15:0] a,
                                              input logic [15:0] b, input logic c);
        logic [16:0] r;
        case (op)
            OP_ADD:  r = {1'b0, a} + {1'b0, b} + {16'd0, c};
            OP_SUB:  r = {1'b0, a} - {1'b0, b} - {16'd0, c};
            OP_AND:  r = {1'b0, a & b};
            OP_NOT:  r = {1'b0, ~a};
            default: r = {1'b0, a};
        endcase
        return r;
    endfunction

    assign {alu_c, alu_f} = alu_model(alu_op, alu_a, alu_b, alu_cin);

    typedef struct {
        logic        ld;
        logic [3:0]  op;
        logic [1:0]  rd;
        logic [1:0]  rs;
        logic [1:0]  rt;
        logic        cuse;
        logic [15:0] imm;
        logic [15:0] exp_val;
        logic        exp_flag;
    } vec_t;

    typedef struct {
        logic [1:0]  rd;
        logic [15:0] val;
        logic        flag;
    } exp_t;

    vec_t        vecs [14];
    exp_t        sbq [$];
    logic [15:0] mregs [4];
    logic        mflag;
    int          checks = 0;
    int          errors = 0;

    function automatic vec_t mk_ld(input logic [1:0] rd, input logic [15:0] imm, input logic f);
        vec_t v;
        v.ld = 1'b1; v.op = 4'h0; v.rd = rd; v.rs = 2'd0; v.rt = 2'd0; v.cuse = 1'b0;
        v.imm = imm; v.exp_val = imm; v.exp_flag = f;
        return v;
    endfunction

    function automatic vec_t mk_op(input logic [3:0] op, input logic [1:0] rd, input logic [1:0] rs,
                                   input logic [1:0] rt, input logic cuse,
                                   input logic [15:0] ev, input logic f);
        vec_t v;
        v.ld = 1'b0; v.op = op; v.rd = rd; v.rs = rs; v.rt = rt; v.cuse = cuse;
        v.imm = 16'h0; v.exp_val = ev; v.exp_flag = f;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Called at a negedge; returns at a negedge.
    task automatic run_vec(input vec_t v);
        int   waitc;
        int   lat;
        exp_t e;
        waitc = 0;
        while (!instr_ready && waitc < 10) begin
            @(negedge clk);
            waitc++;
        end
        chk("ready_before_issue", 32'(instr_ready), 32'd1);
        instr_ld = v.ld; instr_op = v.op; instr_rd = v.rd; instr_rs = v.rs;
        instr_rt = v.rt; instr_cuse = v.cuse; instr_imm = v.imm; instr_valid = 1'b1;
        e.rd = v.rd; e.val = v.exp_val; e.flag = v.exp_flag;
        sbq.push_back(e);
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        if (!v.ld) begin
            chk("alu_a", 32'(alu_a), 32'(mregs[v.rs]));
            chk("alu_b", 32'(alu_b), 32'(mregs[v.rt]));
            chk("alu_op", 32'(alu_op), 32'(v.op));
            chk("alu_c", 32'(alu_cin), 32'(v.cuse & mflag));
            chk("ready_in_exec", 32'(instr_ready), 32'(BYP));
        end
        lat = 1;
        while (!done && lat < 6) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("done_latency", 32'(lat), v.ld ? 32'd1 : 32'd2);
        if (sbq.size() == 0) begin
            chk("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            e = sbq.pop_front();
            dbg_addr = e.rd;
            #1;
            chk("reg_value", 32'(dbg_data), 32'(e.val));
            chk("carry_flag", 32'(dbg_carry), 32'(e.flag));
            mregs[e.rd] = e.val;
            mflag = e.flag;
        end
        @(posedge clk);
        #1;
        chk("done_one_cycle", 32'(done), 32'd0);
        @(negedge clk);
    endtask

    initial begin
        int rdy;
        int acc_n;
        int acc_cyc [2];
        vec_t v;

        vecs[0]  = mk_ld(2'd1, 16'h0002, 1'b0);
        vecs[1]  = mk_ld(2'd2, 16'h0003, 1'b0);
        vecs[2]  = mk_op(OP_ADD, 2'd3, 2'd1, 2'd2, 1'b0, 16'h0005, 1'b0);
        vecs[3]  = mk_ld(2'd0, 16'hFFFF, 1'b0);
        vecs[4]  = mk_ld(2'd1, 16'h0001, 1'b0);
        vecs[5]  = mk_op(OP_ADD, 2'd2, 2'd0, 2'd1, 1'b0, 16'h0000, 1'b1);
        vecs[6]  = mk_op(OP_ADD, 2'd3, 2'd2, 2'd2, 1'b1, 16'h0001, 1'b0);
        vecs[7]  = mk_ld(2'd0, 16'h0000, 1'b0);
        vecs[8]  = mk_ld(2'd1, 16'h0001, 1'b0);
        vecs[9]  = mk_op(OP_SUB, 2'd2, 2'd0, 2'd1, 1'b0, 16'hFFFF, 1'b1);
        vecs[10] = mk_op(OP_NOT, 2'd3, 2'd2, 2'd0, 1'b0, 16'h0000, 1'b0);
        vecs[11] = mk_ld(2'd1, 16'h0007, 1'b0);
        vecs[12] = mk_op(OP_ADD, 2'd1, 2'd1, 2'd1, 1'b0, 16'h000E, 1'b0);
        vecs[13] = mk_op(OP_ADD, 2'd2, 2'd2, 2'd2, 1'b0, 16'hFFFE, 1'b1);

        for (int i = 0; i < 4; i++) mregs[i] = 16'h0;
        mflag = 1'b0;
        rst = 1'b1; instr_valid = 1'b0; instr_ld = 1'b0; instr_op = 4'h0;
        instr_rd = 2'd0; instr_rs = 2'd0; instr_rt = 2'd0; instr_cuse = 1'b0;
        instr_imm = 16'h0; dbg_addr = 2'd0;
        repeat (2) @(negedge clk);

        chk("rst_ready", 32'(instr_ready), 32'd1);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_alu_a", 32'(alu_a), 32'd0);
        chk("rst_alu_b", 32'(alu_b), 32'd0);
        chk("rst_alu_op", 32'(alu_op), 32'd0);
        chk("rst_alu_c", 32'(alu_cin), 32'd0);
        chk("rst_carry", 32'(dbg_carry), 32'd0);
        for (int i = 0; i < 4; i++) begin
            dbg_addr = 2'(i);
            #1;
            chk("rst_reg", 32'(dbg_data), 32'd0);
        end
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 14; i++) run_vec(vecs[i]);

        // Load with the flag set must leave it set; then carry-in from the flag and an AND.
        run_vec(mk_ld(2'd3, 16'h0000, 1'b1));
        run_vec(mk_op(OP_ADD, 2'd0, 2'd1, 2'd3, 1'b1, 16'h000F, 1'b0));
        run_vec(mk_op(OP_AND, 2'd3, 2'd2, 2'd1, 1'b0, 16'h000E, 1'b0));

        // Hold valid with two dependent ADD r1 = r1 + r1 starting from r1 = 1.
        run_vec(mk_ld(2'd1, 16'h0001, 1'b0));
        instr_ld = 1'b0; instr_op = OP_ADD; instr_rd = 2'd1; instr_rs = 2'd1;
        instr_rt = 2'd1; instr_cuse = 1'b0; instr_valid = 1'b1;
        acc_n = 0; acc_cyc[0] = -1; acc_cyc[1] = -1;
        for (int c = 0; c < 8 && acc_n < 2; c++) begin
            rdy = int'(instr_ready);
            @(posedge clk);
            if (rdy == 1) begin
                acc_cyc[acc_n] = c;
                acc_n++;
            end
            #1;
            if (acc_n == 2) instr_valid = 1'b0;
            @(negedge clk);
        end
        instr_valid = 1'b0;
        chk("hold_accept_count", 32'(acc_n), 32'd2);
        chk("hold_accept_spacing", 32'(acc_cyc[1] - acc_cyc[0]), BYP ? 32'd1 : 32'd2);
        repeat (4) @(negedge clk);
        dbg_addr = 2'd1;
        #1;
        chk("hold_r1_final", 32'(dbg_data), 32'h0004);
        chk("hold_flag_final", 32'(dbg_carry), 32'd0);
        mregs[1] = 16'h0004;
        @(negedge clk);

        // Reset in the middle of EXEC for ADD r3 = 5 + 6; r3 currently holds 0x000E.
        run_vec(mk_ld(2'd1, 16'h0005, 1'b0));
        run_vec(mk_ld(2'd2, 16'h0006, 1'b0));
        v = mk_op(OP_ADD, 2'd3, 2'd1, 2'd2, 1'b0, 16'h000B, 1'b0);
        instr_ld = v.ld; instr_op = v.op; instr_rd = v.rd; instr_rs = v.rs;
        instr_rt = v.rt; instr_cuse = v.cuse; instr_valid = 1'b1;
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        chk("pre_rst_alu_a", 32'(alu_a), 32'h0005);
        rst = 1'b1;
        dbg_addr = 2'd3;
        #1;
        chk("mid_rst_ready", 32'(instr_ready), 32'd1);
        chk("mid_rst_done", 32'(done), 32'd0);
        chk("mid_rst_carry", 32'(dbg_carry), 32'd0);
        chk("mid_rst_r3", 32'(dbg_data), 32'd0);
        chk("mid_rst_alu_a", 32'(alu_a), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            chk("post_rst_no_done", 32'(done), 32'd0);
        end
        chk("post_rst_r3", 32'(dbg_data), 32'd0);
        chk("post_rst_carry", 32'(dbg_carry), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
